// File: rtl/axi3_hp_multi_burst_reader.sv
// axi3_hp_multi_burst_reader
// AXI3 HP-port read master: one DMA_START fetches DMA_BURST_COUNT consecutive
// fixed-length INCR bursts with up to MAX_OUTSTANDING address requests in flight.
// Read data streams straight through to the line FIFO, and the FIFO ready signal
// drives RREADY.
//
// Handshake semantics: a transfer happens on any rising CLK edge where valid and
// ready are both high. The producer holds valid and payload stable until that
// edge, and ready may change freely in any cycle.
//
// Optional build macro: AXI_RRESP_ERR_EN adds the sticky DMA_ERROR output.
// It is set by any accepted beat with a non-OKAY rresp.
module axi3_hp_multi_burst_reader #(
    parameter int DATA_WIDTH      = 32,
    parameter int BURST_LEN       = 8,
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [31:0]           DMA_RD_ADDR,
    input  logic [CNT_WIDTH-1:0]  DMA_BURST_COUNT,
    input  logic                  DMA_START,
    output logic                  DMA_READY,
    output logic                  DMA_DONE,
    output logic [DATA_WIDTH-1:0] DMA_RD_DATA,
    output logic                  DMA_RD_DATA_VALID,
    input  logic                  DMA_RD_DATA_READY,
    input  logic                  m00_axi_arready,
    output logic [31:0]           m00_axi_araddr,
    output logic [3:0]            m00_axi_arlen,
    output logic [2:0]            m00_axi_arsize,
    output logic [1:0]            m00_axi_arburst,
    output logic                  m00_axi_arvalid,
    input  logic [DATA_WIDTH-1:0] m00_axi_rdata,
    input  logic [1:0]            m00_axi_rresp,
    input  logic                  m00_axi_rlast,
    input  logic                  m00_axi_rvalid,
    output logic                  m00_axi_rready,
`ifdef AXI_RRESP_ERR_EN
    output logic                  DMA_ERROR,
`endif
    output logic                  dbg_state_o
);

    // Bytes covered by one burst; the address step between consecutive ARs.
    localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * DATA_WIDTH / 8);
    localparam logic [3:0]  ARLEN       = 4'(BURST_LEN - 1);
    localparam logic [2:0]  ARSIZE      = (DATA_WIDTH == 64) ? 3'd3 : 3'd2;
    // Three bits hold any outstanding count up to the legal maximum of 4.
    localparam int          OW          = 3;
    localparam logic [OW-1:0] MAX_OUT   = OW'(MAX_OUTSTANDING);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          addr_q, addr_d;
    logic [CNT_WIDTH-1:0] ar_left_q, ar_left_d;
    logic [CNT_WIDTH-1:0] rd_left_q, rd_left_d;
    logic [OW-1:0]        outst_q, outst_d;
    logic                 zero_done_q, zero_done_d;

    logic ar_hs;
    logic r_hs;
    logic last_hs;
    logic final_beat;
    logic start_ok;

    // Handshake decode and the combinational AXI/DMA outputs.
    // arvalid depends only on registered state. Once it is raised, only an AR
    // handshake can lower ar_left or raise outst, so it stays up until arready.
    always_comb begin
        start_ok          = (state_q == ST_IDLE) && DMA_START;
        m00_axi_arvalid   = (state_q == ST_RUN) && (ar_left_q != '0) && (outst_q < MAX_OUT);
        m00_axi_rready    = (state_q == ST_RUN) && DMA_RD_DATA_READY;
        ar_hs             = m00_axi_arvalid && m00_axi_arready;
        r_hs              = m00_axi_rvalid && m00_axi_rready;
        last_hs           = r_hs && m00_axi_rlast;
        final_beat        = last_hs && (rd_left_q == CNT_ONE);
        m00_axi_araddr    = addr_q;
        m00_axi_arlen     = ARLEN;
        m00_axi_arsize    = ARSIZE;
        m00_axi_arburst   = 2'b01;
        DMA_RD_DATA       = m00_axi_rdata;
        DMA_RD_DATA_VALID = r_hs;
        DMA_READY         = (state_q == ST_IDLE);
        DMA_DONE          = zero_done_q || final_beat;
        dbg_state_o       = state_q;
    end

    // Next-state logic for the command FSM and its counters.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        ar_left_d   = ar_left_q;
        rd_left_d   = rd_left_q;
        outst_d     = outst_q;
        zero_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (DMA_START) begin
                    if (DMA_BURST_COUNT != '0) begin
                        addr_d    = DMA_RD_ADDR;
                        ar_left_d = DMA_BURST_COUNT;
                        rd_left_d = DMA_BURST_COUNT;
                        outst_d   = '0;
                        state_d   = ST_RUN;
                    end else begin
                        // An empty command completes at once without touching AXI.
                        zero_done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (ar_hs) begin
                    addr_d    = addr_q + BURST_BYTES;
                    ar_left_d = ar_left_q - CNT_ONE;
                end
                // An AR accepted in the same cycle as an rlast beat leaves the count as it is.
                case ({ar_hs, last_hs})
                    2'b10:   outst_d = outst_q + OW'(1);
                    2'b01:   outst_d = outst_q - OW'(1);
                    default: outst_d = outst_q;
                endcase
                if (last_hs) begin
                    rd_left_d = rd_left_q - CNT_ONE;
                end
                if (final_beat) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and counter registers with synchronous active-high reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            ar_left_q   <= '0;
            rd_left_q   <= '0;
            outst_q     <= '0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            ar_left_q   <= ar_left_d;
            rd_left_q   <= rd_left_d;
            outst_q     <= outst_d;
            zero_done_q <= zero_done_d;
        end
    end

`ifdef AXI_RRESP_ERR_EN
    logic err_q, err_d;

    // Sticky error flag. An accepted start clears it, and any errored beat sets it.
    always_comb begin
        err_d = err_q;
        if (start_ok) begin
            err_d = 1'b0;
        end
        if (r_hs && (m00_axi_rresp != 2'b00)) begin
            err_d = 1'b1;
        end
    end

    // Error flag register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign DMA_ERROR = err_q;
`else
    // Without error reporting, rresp and the accepted-start decode have no consumer.
    logic unused_rresp;
    assign unused_rresp = ^{m00_axi_rresp, start_ok};
`endif

endmodule

// File: tb/tb_axi3_hp_multi_burst_reader.sv
// Directed bench for axi3_hp_multi_burst_reader.
// The main instance uses the default parameters: 32-bit data and 8 beats per burst,
// so each burst is 32 bytes. A second instance uses 64-bit data and 16-beat bursts
// to check the address channel.
module tb_axi3_hp_multi_burst_reader;

  localparam int DW = 32;
  localparam int BL = 8;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  // ---------------- main DUT signals ----------------
  logic [31:0]   dma_addr;
  logic [7:0]    dma_count;
  logic          dma_start;
  logic          dma_ready;
  logic          dma_done;
  logic [DW-1:0] dma_data;
  logic          dma_valid;
  logic          fifo_rdy;
  logic          arready;
  logic [31:0]   araddr;
  logic [3:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;
  logic          dbg_state;
`ifdef AXI_RRESP_ERR_EN
  logic          dma_error;
`endif

  // ---------------- 64-bit DUT signals ----------------
  logic [31:0] d64_addr;
  logic [7:0]  d64_count;
  logic        d64_start;
  logic        d64_ready;
  logic        d64_done;
  logic [63:0] d64_data;
  logic        d64_valid;
  logic        d64_arready;
  logic [31:0] d64_araddr;
  logic [3:0]  d64_arlen;
  logic [2:0]  d64_arsize;
  logic [1:0]  d64_arburst;
  logic        d64_arvalid;
  logic        d64_rready;
  logic        d64_dbg;
`ifdef AXI_RRESP_ERR_EN
  logic        d64_error;
`endif

  // ---------------- bench state ----------------
  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_ar_q[$];
  logic [31:0] sl_addr_q[$];
  int          sl_time_q[$];
  int cyc = 0;
  int slave_delay = 0;
  int sl_beat = 0;
  logic ar_hold = 1'b0;
  logic [1:0] resp_inj = 2'b00;
  int beat_cnt, data_err, ar_cnt, ar_err, done_cnt, stab_err, mirror_err;
  int outst, max_outst, ar_idx, rl_idx;
  int ar_cyc[16];
  int rlast_cyc[16];
  logic arv_prev, ard_prev;
  logic [31:0] addr_prev;
  bit ok;

  assign arready = !ar_hold;

  axi3_hp_multi_burst_reader u_dut (
    .CLK(CLK), .RESET(RESET),
    .DMA_RD_ADDR(dma_addr), .DMA_BURST_COUNT(dma_count), .DMA_START(dma_start),
    .DMA_READY(dma_ready), .DMA_DONE(dma_done),
    .DMA_RD_DATA(dma_data), .DMA_RD_DATA_VALID(dma_valid), .DMA_RD_DATA_READY(fifo_rdy),
    .m00_axi_arready(arready), .m00_axi_araddr(araddr), .m00_axi_arlen(arlen),
    .m00_axi_arsize(arsize), .m00_axi_arburst(arburst), .m00_axi_arvalid(arvalid),
    .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rlast(rlast),
    .m00_axi_rvalid(rvalid), .m00_axi_rready(rready),
`ifdef AXI_RRESP_ERR_EN
    .DMA_ERROR(dma_error),
`endif
    .dbg_state_o(dbg_state)
  );

  axi3_hp_multi_burst_reader #(.DATA_WIDTH(64), .BURST_LEN(16), .MAX_OUTSTANDING(2), .CNT_WIDTH(8)) u_dut64 (
    .CLK(CLK), .RESET(RESET),
    .DMA_RD_ADDR(d64_addr), .DMA_BURST_COUNT(d64_count), .DMA_START(d64_start),
    .DMA_READY(d64_ready), .DMA_DONE(d64_done),
    .DMA_RD_DATA(d64_data), .DMA_RD_DATA_VALID(d64_valid), .DMA_RD_DATA_READY(1'b1),
    .m00_axi_arready(d64_arready), .m00_axi_araddr(d64_araddr), .m00_axi_arlen(d64_arlen),
    .m00_axi_arsize(d64_arsize), .m00_axi_arburst(d64_arburst), .m00_axi_arvalid(d64_arvalid),
    .m00_axi_rdata(64'd0), .m00_axi_rresp(2'b00), .m00_axi_rlast(1'b0),
    .m00_axi_rvalid(1'b0), .m00_axi_rready(d64_rready),
`ifdef AXI_RRESP_ERR_EN
    .DMA_ERROR(d64_error),
`endif
    .dbg_state_o(d64_dbg)
  );

  // ---------------- AXI slave model + scoreboard monitor ----------------
  initial begin
    rvalid = 1'b0; rdata = '0; rlast = 1'b0; rresp = 2'b00;
    arv_prev = 1'b0; ard_prev = 1'b0; addr_prev = '0;
    forever begin
      @(posedge CLK);
      cyc++;
      if (RESET) begin
        sl_addr_q.delete();
        sl_time_q.delete();
        sl_beat = 0;
        outst = 0;
      end else begin
        if (arvalid && arready) begin
          ar_cnt++;
          if (exp_ar_q.size() == 0) ar_err++;
          else if (exp_ar_q.pop_front() !== araddr) ar_err++;
          sl_addr_q.push_back(araddr);
          sl_time_q.push_back(cyc + slave_delay);
          outst++;
          if (ar_idx < 16) ar_cyc[ar_idx] = cyc;
          ar_idx++;
        end
        if (arv_prev && !ard_prev && (!arvalid || araddr !== addr_prev)) stab_err++;
        if (rvalid && rready) begin
          if (rlast) begin
            outst--;
            void'(sl_addr_q.pop_front());
            void'(sl_time_q.pop_front());
            sl_beat = 0;
            if (rl_idx < 16) rlast_cyc[rl_idx] = cyc;
            rl_idx++;
          end else begin
            sl_beat++;
          end
        end
        if (dma_valid) begin
          beat_cnt++;
          if (exp_q.size() == 0) data_err++;
          else if (exp_q.pop_front() !== dma_data) data_err++;
        end
        if (dma_done) done_cnt++;
        if (rready !== (dma_ready ? 1'b0 : fifo_rdy)) mirror_err++;
        if (dma_valid !== (rvalid && rready)) mirror_err++;
        if (outst > max_outst) max_outst = outst;
      end
      arv_prev = arvalid;
      ard_prev = arready;
      addr_prev = araddr;
      #1;
      rresp = resp_inj;
      if (sl_addr_q.size() > 0 && cyc >= sl_time_q[0]) begin
        rvalid = 1'b1;
        rdata = sl_addr_q[0] + 32'(sl_beat * 4);
        rlast = (sl_beat == BL - 1);
      end else begin
        rvalid = 1'b0;
        rlast = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic clear_stats();
    beat_cnt = 0; data_err = 0; ar_cnt = 0; ar_err = 0; done_cnt = 0;
    stab_err = 0; mirror_err = 0; max_outst = 0; ar_idx = 0; rl_idx = 0;
  endtask

  task automatic cmd(input logic [31:0] a, input int n);
    dma_addr = a;
    dma_count = 8'(n);
    dma_start = 1'b1;
    for (int b = 0; b < n; b++) begin
      exp_ar_q.push_back(a + 32'(b * 32));
      for (int k = 0; k < BL; k++) exp_q.push_back(a + 32'(b * 32 + k * 4));
    end
    @(posedge CLK);
    #1;
    dma_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit toggle, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge CLK);
      if (dma_done === 1'b1) got = 1'b1;
      #1;
      if (toggle) fifo_rdy = ~fifo_rdy;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    RESET = 1'b1;
    dma_addr = '0; dma_count = '0; dma_start = 1'b0; fifo_rdy = 1'b1;
    d64_addr = '0; d64_count = '0; d64_start = 1'b0; d64_arready = 1'b0;
    clear_stats();
    outst = 0;
    step(3);
    RESET = 1'b0;
    step(1);

    // Reset state
    chk("rst_ready", 32'(dma_ready), 32'd1);
    chk("rst_done", 32'(dma_done), 32'd0);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("arlen", 32'(arlen), 32'd7);
    chk("arsize", 32'(arsize), 32'd2);
    chk("arburst", 32'(arburst), 32'd1);

    // 1: four bursts, everything ready
    clear_stats();
    slave_delay = 0;
    cmd(32'h1000_0000, 4);
    wait_done(300, 1'b0, ok);
    chk("t1_done_seen", 32'(ok), 32'd1);
    chk("t1_ready_after", 32'(dma_ready), 32'd1);
    chk("t1_beats", 32'(beat_cnt), 32'd32);
    chk("t1_data_err", 32'(data_err), 32'd0);
    chk("t1_ar_cnt", 32'(ar_cnt), 32'd4);
    chk("t1_ar_err", 32'(ar_err), 32'd0);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_mirror", 32'(mirror_err), 32'd0);

    // 2: slow slave, outstanding limit
    clear_stats();
    slave_delay = 20;
    cmd(32'h2000_0000, 4);
    wait_done(600, 1'b0, ok);
    chk("t2_done_seen", 32'(ok), 32'd1);
    chk("t2_max_outst", 32'(max_outst), 32'd2);
    chk("t2_third_ar_gap", 32'(ar_cyc[2] - rlast_cyc[0]), 32'd1);
    chk("t2_beats", 32'(beat_cnt), 32'd32);
    chk("t2_data_err", 32'(data_err), 32'd0);
    chk("t2_ar_err", 32'(ar_err), 32'd0);
    slave_delay = 0;

    // 3: FIFO ready toggling
    clear_stats();
    fifo_rdy = 1'b1;
    cmd(32'h0000_0400, 2);
    wait_done(300, 1'b1, ok);
    fifo_rdy = 1'b1;
    chk("t3_done_seen", 32'(ok), 32'd1);
    chk("t3_beats", 32'(beat_cnt), 32'd16);
    chk("t3_data_err", 32'(data_err), 32'd0);
    chk("t3_exp_left", 32'(exp_q.size()), 32'd0);
    chk("t3_mirror", 32'(mirror_err), 32'd0);

    // 4: arready stalled, STARTs while busy ignored
    clear_stats();
    ar_hold = 1'b1;
    cmd(32'h3000_0040, 1);
    for (int i = 0; i < 10; i++) begin
      dma_addr = 32'h7000_0000;
      dma_count = 8'd3;
      dma_start = (i % 2 == 0);
      step(1);
    end
    dma_start = 1'b0;
    chk("t4_arvalid_held", 32'(arvalid), 32'd1);
    chk("t4_araddr_held", araddr, 32'h3000_0040);
    chk("t4_stable", 32'(stab_err), 32'd0);
    chk("t4_no_ar_yet", 32'(ar_cnt), 32'd0);
    chk("t4_state_run", 32'(dbg_state), 32'd1);
    ar_hold = 1'b0;
    wait_done(300, 1'b0, ok);
    chk("t4_done_seen", 32'(ok), 32'd1);
    step(5);
    chk("t4_ar_cnt", 32'(ar_cnt), 32'd1);
    chk("t4_beats", 32'(beat_cnt), 32'd8);
    chk("t4_data_err", 32'(data_err), 32'd0);
    chk("t4_done_cnt", 32'(done_cnt), 32'd1);
    chk("t4_ready", 32'(dma_ready), 32'd1);

    // 5a: zero-count command
    clear_stats();
    cmd(32'h6000_0000, 0);
    chk("t5_zero_done", 32'(dma_done), 32'd1);
    chk("t5_zero_arvalid", 32'(arvalid), 32'd0);
    chk("t5_zero_ready", 32'(dma_ready), 32'd1);
    step(1);
    chk("t5_zero_done_drop", 32'(dma_done), 32'd0);
    step(3);
    chk("t5_zero_ar_cnt", 32'(ar_cnt), 32'd0);
    chk("t5_zero_done_cnt", 32'(done_cnt), 32'd1);

    // 5b: 64-bit data, 16-beat bursts at the top page of the address space
    d64_addr = 32'hFFFF_F000;
    d64_count = 8'd2;
    d64_start = 1'b1;
    d64_arready = 1'b1;
    step(1);
    d64_start = 1'b0;
    chk("t5_64_arsize", 32'(d64_arsize), 32'd3);
    chk("t5_64_arlen", 32'(d64_arlen), 32'd15);
    chk("t5_64_arvalid0", 32'(d64_arvalid), 32'd1);
    chk("t5_64_addr0", d64_araddr, 32'hFFFF_F000);
    step(1);
    chk("t5_64_arvalid1", 32'(d64_arvalid), 32'd1);
    chk("t5_64_addr1", d64_araddr, 32'hFFFF_F080);
    step(1);
    chk("t5_64_arvalid_off", 32'(d64_arvalid), 32'd0);
    chk("t5_64_busy", 32'(d64_ready), 32'd0);

    // 6: reset mid-burst, then a fresh command
    clear_stats();
    cmd(32'h4000_0000, 4);
    for (int i = 0; i < 200 && beat_cnt < 5; i++) step(1);
    chk("t6_mid_burst", 32'(beat_cnt >= 5), 32'd1);
    RESET = 1'b1;
    step(1);
    RESET = 1'b0;
    exp_q.delete();
    exp_ar_q.delete();
    chk("t6_rst_ready", 32'(dma_ready), 32'd1);
    chk("t6_rst_arvalid", 32'(arvalid), 32'd0);
    chk("t6_rst_rready", 32'(rready), 32'd0);
    chk("t6_rst_done", 32'(dma_done), 32'd0);
    chk("t6_rst_valid", 32'(dma_valid), 32'd0);
    step(1);
    clear_stats();
    cmd(32'h5000_0000, 4);
    wait_done(300, 1'b0, ok);
    chk("t6_done_seen", 32'(ok), 32'd1);
    chk("t6_beats", 32'(beat_cnt), 32'd32);
    chk("t6_data_err", 32'(data_err), 32'd0);
    chk("t6_ar_err", 32'(ar_err), 32'd0);
    chk("t6_done_cnt", 32'(done_cnt), 32'd1);
    chk("t6_ready", 32'(dma_ready), 32'd1);

`ifdef AXI_RRESP_ERR_EN
    // Error flag: set by SLVERR beats, held until the next accepted START
    chk("err_clear_initial", 32'(dma_error), 32'd0);
    clear_stats();
    resp_inj = 2'b10;
    cmd(32'h5000_1000, 1);
    wait_done(300, 1'b0, ok);
    resp_inj = 2'b00;
    chk("err_done_seen", 32'(ok), 32'd1);
    chk("err_data_err", 32'(data_err), 32'd0);
    chk("err_set", 32'(dma_error), 32'd1);
    step(3);
    chk("err_sticky", 32'(dma_error), 32'd1);
    cmd(32'h5000_2000, 1);
    chk("err_cleared_by_start", 32'(dma_error), 32'd0);
    wait_done(300, 1'b0, ok);
    chk("err_stays_clear", 32'(dma_error), 32'd0);
`endif

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
